// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg
//   Shared definitions for the digit-serial arithmetic blocks.
//   - state_t  : controller state encoding (2 bits)
//   - MODE_*   : operation select values for mode_in
//   - cnt_width: width of a digit counter that must reach n-1 (minimum 1)
package serial_arith_pkg;

  // Each control output maps onto one state bit, so busy/done come straight
  // off a flop with no decode logic in between.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_add_sub_digit_add.sv
// digit_add
//   Combinational DIGIT-bit ripple adder used as the shared digit cell of
//   serial_add_sub. With DIGIT=1 it is a plain full adder.
//   Ports:
//     a, b      : DIGIT-bit operand digits
//     cin       : carry into bit 0
//     sum       : DIGIT-bit sum digit
//     cout      : carry out of the top bit
//     c_msb_in  : carry into the top bit (used for signed-overflow detection)
module digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  always_comb begin
    logic c;
    // NOTE: blocking assignments here model the carry rippling bit by bit
    // within one evaluation; every output gets a default first so no latch
    // can be inferred.
    c        = cin;
    sum      = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Digit-serial adder/subtractor. Operands are captured on an accepted
//   start, then processed DIGIT bits per clock, LSB first, through one
//   shared digit_add cell. Subtraction is a + ~b + 1 (B inverted at load,
//   carry register preset to 1).
//   Parameters:
//     WIDTH : operand/result width, multiple of DIGIT
//     DIGIT : bits processed per clock, 1..WIDTH
//   Ports:
//     clk_in     : clock, rising edge
//     rst_in     : synchronous active-high reset
//     start_in   : request, sampled only in IDLE
//     mode_in    : 0 = add, 1 = subtract (sampled with start_in)
//     a_in, b_in : operands (sampled with start_in)
//     busy_out   : high while digits are being processed
//     done_out   : one-cycle pulse when result/flags are valid
//     result_out : sum or difference, two's complement
//     cb_out     : carry-out (add) or borrow-out (subtract)
//     ovf_out    : signed overflow
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             mode_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] result_out,
  output logic             cb_out,
  output logic             ovf_out
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             mode_q;
  logic [WIDTH-1:0] a_sr, b_sr, acc_q;
  logic [WIDTH-1:0] acc_next;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_c_msb;

  logic accept;
  logic last_digit;

  assign accept     = (state_q == ST_IDLE) && start_in;
  assign last_digit = (cnt_q == CNT_W'(N - 1));

  // ---------------------------------------------------------------------
  // Shared digit cell
  // ---------------------------------------------------------------------
  digit_add #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a        (a_sr[DIGIT-1:0]),
    .b        (b_sr[DIGIT-1:0]),
    .cin      (carry_q),
    .sum      (dig_sum),
    .cout     (dig_cout),
    .c_msb_in (dig_c_msb)
  );

  // New digit enters at the MSB end; after N shifts digit 0 sits at the LSB.
  assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state is always updated with non-blocking assignments
  // so every flop samples values from before the edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_in)   state_d = ST_RUN;
      ST_RUN:  if (last_digit) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (direct state bits, hence registered and mutually
  // exclusive by construction)
  // ---------------------------------------------------------------------
  always_comb begin
    busy_out = state_q[0];
    done_out = state_q[1];
  end

  // ---------------------------------------------------------------------
  // Operand/accumulator shift registers
  // ---------------------------------------------------------------------
  // NOTE: these datapath registers carry no reset; they are always loaded
  // on an accepted start before anything reads them, and nothing visible
  // depends on their contents outside RUN.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      a_sr <= a_in;
      b_sr <= (mode_in == MODE_SUB) ? ~b_in : b_in;
    end else if (state_q == ST_RUN) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      acc_q <= acc_next;
    end
  end

  // ---------------------------------------------------------------------
  // Counter, carry and visible results
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      mode_q     <= MODE_ADD;
      result_out <= '0;
      cb_out     <= 1'b0;
      ovf_out    <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      carry_q <= mode_in;   // +1 of the two's-complement negate for subtract
      mode_q  <= mode_in;
    end else if (state_q == ST_RUN) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      carry_q <= dig_cout;
      // Visible outputs change only once the whole word is formed.
      if (last_digit) begin
        result_out <= acc_next;
        cb_out     <= dig_cout ^ mode_q;
        ovf_out    <= dig_c_msb ^ dig_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: one 8-bit/1-bit-digit instance and one
// 16-bit/4-bit-digit instance. Stimulus pushes expected results into a
// per-instance queue; a monitor pops and compares on every done pulse.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, DIGIT=1 instance
  logic       rst8, start8, mode8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cb8, ovf8;
  logic [7:0] res8;

  // 16-bit, DIGIT=4 instance
  logic        rst16, start16, mode16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cb16, ovf16;
  logic [15:0] res16;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk_in(clk), .rst_in(rst8), .start_in(start8), .mode_in(mode8),
    .a_in(a8), .b_in(b8), .busy_out(busy8), .done_out(done8),
    .result_out(res8), .cb_out(cb8), .ovf_out(ovf8)
  );

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk_in(clk), .rst_in(rst16), .start_in(start16), .mode_in(mode16),
    .a_in(a16), .b_in(b16), .busy_out(busy16), .done_out(done16),
    .result_out(res16), .cb_out(cb16), .ovf_out(ovf16)
  );

  typedef struct {
    logic [15:0] r;
    logic        cb;
    logic        ovf;
  } exp_t;

  typedef struct {
    bit          wide;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [15:0] r;
    logic        cb;
    logic        ovf;
    string       name;
  } vec_t;

  exp_t q8[$];
  exp_t q16[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   dones8   = 0;
  int   dones16  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------
  // Monitors: pop the oldest expectation whenever a done pulse is seen
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    if (done8) begin
      exp_t e;
      dones8++;
      if (q8.size() == 0) begin
        check("dut8 unexpected done", 1, 0);
      end else begin
        e = q8.pop_front();
        check("dut8 result/cb/ovf", {res8, cb8, ovf8}, {e.r[7:0], e.cb, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      exp_t e;
      dones16++;
      if (q16.size() == 0) begin
        check("dut16 unexpected done", 1, 0);
      end else begin
        e = q16.pop_front();
        check("dut16 result/cb/ovf", {res16, cb16, ovf16}, {e.r, e.cb, e.ovf});
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------
  function automatic logic get_busy(input bit wide);
    return wide ? busy16 : busy8;
  endfunction

  function automatic logic get_done(input bit wide);
    return wide ? done16 : done8;
  endfunction

  task automatic drive_start(input bit wide, input logic [15:0] a,
                             input logic [15:0] b, input logic mode);
    if (wide) begin
      start16 = 1'b1; a16 = a; b16 = b; mode16 = mode;
    end else begin
      start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; mode8 = mode;
    end
  endtask

  task automatic clear_start();
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  // Called #1 after the start edge; counts edges until done (bounded) and
  // the cycles busy was seen high, including the one following the start.
  task automatic wait_done(input bit wide, input string name,
                           output int edges, output int busy_cyc);
    bit got;
    got      = 1'b0;
    edges    = 0;
    busy_cyc = get_busy(wide) ? 1 : 0;
    while (!got && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
      if (get_done(wide)) begin
        got = 1'b1;
        check({name, " busy with done"}, 32'(get_busy(wide)), 0);
      end else if (get_busy(wide)) begin
        busy_cyc++;
      end
    end
  endtask

  // One complete operation. Returns #1 after the edge that re-enters IDLE,
  // so a following call issues its start in that IDLE cycle.
  task automatic run_op(input vec_t v);
    exp_t e;
    int   n, edges, busy_cyc;
    n     = v.wide ? 4 : 8;
    e.r   = v.r;
    e.cb  = v.cb;
    e.ovf = v.ovf;
    if (v.wide) q16.push_back(e);
    else        q8.push_back(e);
    drive_start(v.wide, v.a, v.b, v.mode);
    @(posedge clk);
    #1;
    clear_start();
    wait_done(v.wide, v.name, edges, busy_cyc);
    check({v.name, " latency"}, edges, n);
    check({v.name, " busy cycles"}, busy_cyc, n);
    @(posedge clk);
    #1;
    check({v.name, " done width"}, 32'(get_done(v.wide)), 0);
  endtask

  // Directed vectors, expected values worked out by hand.
  vec_t vecs[12];

  initial begin
    int   edges, busy_cyc, d0;
    vec_t v;

    vecs = '{
      '{1'b0, 16'h0035, 16'h004A, 1'b0, 16'h007F, 1'b0, 1'b0, "add 35+4A"},
      '{1'b0, 16'h0010, 16'h0020, 1'b1, 16'h00F0, 1'b1, 1'b0, "sub 10-20"},
      '{1'b0, 16'h0020, 16'h0010, 1'b1, 16'h0010, 1'b0, 1'b0, "sub 20-10"},
      '{1'b0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, "add 7F+01"},
      '{1'b0, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b0, 1'b1, "sub 80-01"},
      '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add FF+01"},
      '{1'b0, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, "add 80+80"},
      '{1'b0, 16'h0000, 16'h0001, 1'b1, 16'h00FF, 1'b1, 1'b0, "sub 00-01"},
      '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "w add FFFF+0001"},
      '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, "w sub 1234-1234"},
      '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "w add 7FFF+0001"},
      '{1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, "w sub 0003-0005"}
    };

    rst8 = 1'b1; rst16 = 1'b1;
    start8 = 1'b0; start16 = 1'b0;
    mode8 = 1'b0; mode16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0; rst16 = 1'b0;
    check("dut8 reset state", {busy8, done8, res8, cb8, ovf8}, 0);
    check("dut16 reset state", {busy16, done16, res16, cb16, ovf16}, 0);

    // Back-to-back table: each start lands in the IDLE cycle after DONE.
    foreach (vecs[i]) run_op(vecs[i]);

    // Start pulsed during RUN must be ignored, original result delivered.
    d0    = dones8;
    v     = '{1'b0, 16'h0011, 16'h0022, 1'b0, 16'h0033, 1'b0, 1'b0, "ignore start"};
    q8.push_back('{16'h0033, 1'b0, 1'b0});
    drive_start(1'b0, 16'h0011, 16'h0022, 1'b0);
    @(posedge clk);
    #1;
    clear_start();
    repeat (3) @(posedge clk);
    #1;
    drive_start(1'b0, 16'h00FF, 16'h00FF, 1'b1);
    @(posedge clk);
    #1;
    clear_start();
    wait_done(1'b0, v.name, edges, busy_cyc);
    repeat (12) @(posedge clk);
    #1;
    check("ignore start done count", dones8 - d0, 1);

    // Reset sampled at the 3rd RUN edge aborts with no done pulse.
    drive_start(1'b0, 16'h0035, 16'h004A, 1'b0);
    @(posedge clk);
    #1;
    clear_start();
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    check("abort reset state", {busy8, done8, res8, cb8, ovf8}, 0);
    d0 = dones8;
    repeat (12) @(posedge clk);
    #1;
    check("abort no done", dones8 - d0, 0);

    run_op('{1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "add 01+02 after abort"});

    repeat (3) @(posedge clk);
    #1;
    check("dut8 queue drained", q8.size(), 0);
    check("dut16 queue drained", q16.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
